// File: rtl/fp_unit_issuer.sv
// fp_unit_issuer: credit-based go/done issuer for a fixed-latency FP unit with in-order response FIFO.
// Optional done/expect checker is built when FP_ISSUE_CHECK_EN is defined.
module fp_unit_issuer #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 28,
    parameter int DEPTH   = 29
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    output logic             unit_go,
    output logic [WIDTH-1:0] unit_arg,
    input  logic             unit_done,
    input  logic [WIDTH-1:0] unit_result,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             busy,
    output logic             check_err
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [CW-1:0]    credits;
    logic [CW-1:0]    count;
    logic [LATENCY-1:0] expect_sr;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             issue;
    logic             take;
    logic             write;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    assign req_ready  = (credits != '0) & ~reset;
    assign issue      = req_valid & req_ready;
    assign unit_go    = issue;
    assign unit_arg   = req_data;
    assign write      = unit_done & expect_sr[0];
    assign resp_valid = count != '0;
    assign take       = resp_valid & resp_ready;
    assign resp_data  = mem[rd_ptr];
    assign busy       = credits != CW'(DEPTH);

    // Credits, expected-done tracking and FIFO bookkeeping; a credit returns only when the consumer takes a result
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            credits   <= CW'(DEPTH);
            count     <= '0;
            expect_sr <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            credits   <= credits - CW'(issue) + CW'(take);
            count     <= count + CW'(write) - CW'(take);
            expect_sr <= LATENCY'({issue, expect_sr} >> 1);
            wr_ptr    <= write ? nxt(wr_ptr) : wr_ptr;
            rd_ptr    <= take ? nxt(rd_ptr) : rd_ptr;
        end
    end

    // Result storage; credits guarantee a free slot whenever a write happens
    always_ff @(posedge clock) begin
        if (write) mem[wr_ptr] <= unit_result;
    end

`ifdef FP_ISSUE_CHECK_EN
    // Sticky flag for a done that arrives when none is due, or a due done that never arrives
    always_ff @(posedge clock or posedge reset) begin
        if (reset) check_err <= 1'b0;
        else if (unit_done != expect_sr[0]) check_err <= 1'b1;
    end
`else
    assign check_err = 1'b0;
`endif

endmodule

// File: tb/tb_fp_unit_issuer.sv
// tb_fp_unit_issuer: directed self-checking bench for fp_unit_issuer (DEPTH=29 and DEPTH=4 instances).
module tb_fp_unit_issuer;
    localparam int L = 28;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

`ifdef FP_ISSUE_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    function automatic logic [31:0] f(input logic [31:0] x);
        return x == 32'h40800000 ? 32'h40000000 : ~x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic        a_req_valid = 1'b0, a_resp_ready = 1'b0, a_inj = 1'b0;
    logic [31:0] a_req_data = '0, a_inj_val = '0;
    logic        a_req_ready, a_unit_go, a_unit_done, a_resp_valid, a_busy, a_check_err;
    logic [31:0] a_unit_arg, a_unit_result, a_resp_data;
    logic [L-1:0] a_go_sr = '0;
    logic [31:0] a_arg_sr [L];

    logic        b_req_valid = 1'b0, b_resp_ready = 1'b0;
    logic [31:0] b_req_data = '0;
    logic        b_req_ready, b_unit_go, b_unit_done, b_resp_valid, b_busy, b_check_err;
    logic [31:0] b_unit_arg, b_unit_result, b_resp_data;
    logic [L-1:0] b_go_sr = '0;
    logic [31:0] b_arg_sr [L];

    fp_unit_issuer #(.WIDTH(32), .LATENCY(L), .DEPTH(29)) dut_a (
        .clock(clk), .reset(rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_data(a_req_data), .unit_go(a_unit_go), .unit_arg(a_unit_arg),
        .unit_done(a_unit_done), .unit_result(a_unit_result), .resp_valid(a_resp_valid),
        .resp_ready(a_resp_ready), .resp_data(a_resp_data), .busy(a_busy), .check_err(a_check_err)
    );

    fp_unit_issuer #(.WIDTH(32), .LATENCY(L), .DEPTH(4)) dut_b (
        .clock(clk), .reset(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_data(b_req_data), .unit_go(b_unit_go), .unit_arg(b_unit_arg),
        .unit_done(b_unit_done), .unit_result(b_unit_result), .resp_valid(b_resp_valid),
        .resp_ready(b_resp_ready), .resp_data(b_resp_data), .busy(b_busy), .check_err(b_check_err)
    );

    // Fixed-latency FP unit models: go at cycle t gives done at cycle t+L; they ignore the issuer reset
    always @(posedge clk) begin
        a_go_sr <= {a_go_sr[L-2:0], a_unit_go};
        b_go_sr <= {b_go_sr[L-2:0], b_unit_go};
        for (int i = L - 1; i > 0; i--) begin
            a_arg_sr[i] <= a_arg_sr[i-1];
            b_arg_sr[i] <= b_arg_sr[i-1];
        end
        a_arg_sr[0] <= a_unit_arg;
        b_arg_sr[0] <= b_unit_arg;
    end

    assign a_unit_done   = a_go_sr[L-1] | a_inj;
    assign a_unit_result = a_inj ? a_inj_val : f(a_arg_sr[L-1]);
    assign b_unit_done   = b_go_sr[L-1];
    assign b_unit_result = f(b_arg_sr[L-1]);

    int          dq[$];
    logic [31:0] dd[$];

    initial begin
        int c, base, sent, got, mcred;
        bit er, iss, hs;
        // Reset state, including ready/go forced low while reset is high
        repeat (3) step();
        a_req_valid = 1'b1;
        #1;
        chk("rst_req_ready", a_req_ready, 0);
        chk("rst_unit_go", a_unit_go, 0);
        chk("rst_resp_valid", a_resp_valid, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_check_err", a_check_err, 0);
        chk("rst_b_busy", b_busy, 0);
        rst = 1'b0;
        a_req_valid = 1'b0;
        #1;
        chk("post_rst_ready_a", a_req_ready, 1);
        chk("post_rst_ready_b", b_req_ready, 1);
        step();
        // Single op: response visible LATENCY+1 cycles after issue
        c = cyc;
        a_req_valid = 1'b1;
        a_req_data = 32'h40800000;
        #1;
        chk("t1_go", a_unit_go, 1);
        chk("t1_arg", a_unit_arg, 32'h40800000);
        step();
        a_req_valid = 1'b0;
        #1;
        chk("t1_busy", a_busy, 1);
        while (cyc < c + L) step();
        chk("t1_no_bypass", a_resp_valid, 0);
        step();
        chk("t1_resp_valid", a_resp_valid, 1);
        chk("t1_resp_data", a_resp_data, 32'h40000000);
        step();
        chk("t1_hold_valid", a_resp_valid, 1);
        chk("t1_hold_data", a_resp_data, 32'h40000000);
        a_resp_ready = 1'b1;
        step();
        chk("t1_drained", a_resp_valid, 0);
        chk("t1_idle", a_busy, 0);
        // Back-to-back stream against a credit/response model
        sent = 0;
        got = 0;
        mcred = 29;
        for (int n = 0; n < 300 && got < 40; n++) begin
            a_req_valid = sent < 40;
            a_req_data = 32'h1000 + sent;
            #1;
            er = mcred != 0;
            iss = sent < 40 && er;
            hs = dq.size() > 0 && dq[0] == cyc;
            chk("t2_ready", a_req_ready, er);
            chk("t2_go", a_unit_go, iss);
            chk("t2_resp_valid", a_resp_valid, hs);
            if (hs) begin
                chk("t2_resp_data", a_resp_data, dd[0]);
                void'(dq.pop_front());
                void'(dd.pop_front());
                got++;
            end
            if (iss) begin
                dq.push_back(cyc + L + 1);
                dd.push_back(~(32'h1000 + sent));
                sent++;
            end
            mcred = mcred - int'(iss) + int'(hs);
            step();
        end
        a_req_valid = 1'b0;
        chk("t2_count", got, 40);
        #1;
        chk("t2_idle", a_busy, 0);
        chk("t2_check_err", a_check_err, 0);
        // Backpressure and credit-0 boundary on the DEPTH=4 instance
        base = cyc;
        for (int i = 0; i < 4; i++) begin
            b_req_valid = 1'b1;
            b_req_data = 32'h2000 + i;
            #1;
            chk("t3_ready", b_req_ready, 1);
            chk("t3_go", b_unit_go, 1);
            step();
        end
        b_req_data = 32'h2004;
        #1;
        chk("t3_stall_ready", b_req_ready, 0);
        chk("t3_stall_go", b_unit_go, 0);
        step();
        b_req_valid = 1'b0;
        while (cyc < base + 33) step();
        chk("t3_full_valid", b_resp_valid, 1);
        chk("t3_full_data", b_resp_data, ~32'h2000);
        chk("t3_full_ready", b_req_ready, 0);
        step();
        b_resp_ready = 1'b1;
        b_req_valid = 1'b1;
        #1;
        chk("t3_hs0_ready", b_req_ready, 0);
        chk("t3_hs0_go", b_unit_go, 0);
        chk("t3_hs0_data", b_resp_data, ~32'h2000);
        step();
        chk("t3_reassert", b_req_ready, 1);
        chk("t4_go_hs", b_unit_go, 1);
        chk("t3_data1", b_resp_data, ~32'h2001);
        step();
        b_req_data = 32'h2005;
        b_resp_ready = 1'b0;
        #1;
        chk("t4_go5", b_unit_go, 1);
        chk("t4_data2", b_resp_data, ~32'h2002);
        step();
        b_req_data = 32'h2006;
        #1;
        chk("t4_zero_credit", b_req_ready, 0);
        step();
        b_req_valid = 1'b0;
        while (cyc < base + 63) step();
        b_resp_ready = 1'b1;
        b_req_valid = 1'b1;
        #1;
        chk("t4_wr_rd_ready", b_req_ready, 0);
        chk("t4_wr_rd_data2", b_resp_data, ~32'h2002);
        step();
        chk("t4_issue_hs_go", b_unit_go, 1);
        chk("t4_data3", b_resp_data, ~32'h2003);
        step();
        b_req_valid = 1'b0;
        #1;
        chk("t4_data4", b_resp_data, ~32'h2004);
        step();
        chk("t4_data5", b_resp_data, ~32'h2005);
        step();
        chk("t4_gap", b_resp_valid, 0);
        while (cyc < base + 93) step();
        chk("t4_valid6", b_resp_valid, 1);
        chk("t4_data6", b_resp_data, ~32'h2006);
        step();
        chk("t4_drained", b_resp_valid, 0);
        chk("t4_idle", b_busy, 0);
        chk("t4_check_err", b_check_err, 0);
        // Unexpected done with nothing issued
        a_inj = 1'b1;
        a_inj_val = 32'hdeadbeef;
        #1;
        chk("t6_err_same_cycle", a_check_err, 0);
        step();
        a_inj = 1'b0;
        #1;
        chk("t6_resp_valid", a_resp_valid, 0);
        chk("t6_check_err", a_check_err, EXP_ERR);
        step();
        chk("t6_resp_valid2", a_resp_valid, 0);
        // Reset with three ops in flight; their dones must be dropped
        for (int i = 0; i < 3; i++) begin
            a_req_valid = 1'b1;
            a_req_data = 32'h3000 + i;
            step();
        end
        a_req_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        a_req_valid = 1'b1;
        #1;
        chk("t5_rst_ready", a_req_ready, 0);
        chk("t5_rst_go", a_unit_go, 0);
        chk("t5_rst_busy", a_busy, 0);
        chk("t5_rst_err", a_check_err, 0);
        step();
        step();
        rst = 1'b0;
        a_req_valid = 1'b0;
        for (int n = 0; n < 30; n++) begin
            #1;
            chk("t5_resp_valid", a_resp_valid, 0);
            step();
        end
        chk("t5_check_err", a_check_err, EXP_ERR);
        chk("t5_busy", a_busy, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
